// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for reg_access_arbiter: FSM state encoding,
// index sizing and the round-robin priority search.
package reg_arb_pkg;

    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        WAIT,
        ACK
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Index width for n requesters; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of req at or above ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int unsigned          n);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !res.found && req[j[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j[MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority search over NUM_REQ request lines,
// starting from ptr and wrapping.
module rr_picker
    import reg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [MAX_REQ-1:0]   req_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    rr_pick_t             pick;

    always_comb begin
        req_ext                 = '0;
        req_ext[NUM_REQ-1:0]    = req;
        ptr_ext                 = '0;
        ptr_ext[IDX_W-1:0]      = ptr;
        pick                    = rr_pick(req_ext, ptr_ext, NUM_REQ);
        found                   = pick.found;
        grant_idx               = IDX_W'(pick.idx);
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one enable-loaded register between
// NUM_REQ requesters. Optional write-back check: REG_ACCESS_ARBITER_CHECK_EN.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned INIT_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       busy,
    output logic [WIDTH-1:0]           reg_data,
    output logic                       reg_enable,
    output logic                       reg_reset_n,
    input  logic [WIDTH-1:0]           reg_outa
`ifdef REG_ACCESS_ARBITER_CHECK_EN
    ,
    output logic                       wr_err,
    output logic [7:0]                 err_cnt
`endif
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(INIT_CYCLES + 1);

    arb_state_e         state, state_n;
    logic [CNT_W-1:0]   init_cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] ack_n;
    logic               reg_enable_n;
    logic               reg_reset_n_n;
    logic               busy_n;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (req),
        .ptr       (rr_ptr),
        .found     (pick_found),
        .grant_idx (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_n;
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_comb begin
        state_n       = state;
        ack_n         = '0;
        case (state)
            INIT:    if (init_cnt == CNT_W'(INIT_CYCLES - 1)) state_n = IDLE;
            IDLE:    if (pick_found) state_n = WRITE;
            WRITE:   state_n = WAIT;
            WAIT:    state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = INIT;
        endcase
        if (state_n == ACK) ack_n[winner] = 1'b1;
        reg_enable_n  = (state_n == WRITE);
        reg_reset_n_n = (state_n != INIT);
        busy_n        = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt    <= '0;
            rr_ptr      <= '0;
            winner      <= '0;
            reg_data    <= '0;
            rsp_data    <= '0;
            ack         <= '0;
            reg_enable  <= 1'b0;
            reg_reset_n <= 1'b0;
            busy        <= 1'b1;
        end else begin
            if (state == INIT) init_cnt <= init_cnt + CNT_W'(1);
            // reg_data doubles as the latched write data for the transaction.
            if (state == IDLE && pick_found) begin
                winner   <= pick_idx;
                reg_data <= req_data[pick_idx*WIDTH +: WIDTH];
            end
            if (state == WAIT) rsp_data <= reg_outa;
            if (state == ACK) begin
                rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
            end
            ack         <= ack_n;
            reg_enable  <= reg_enable_n;
            reg_reset_n <= reg_reset_n_n;
            busy        <= busy_n;
        end
    end

`ifdef REG_ACCESS_ARBITER_CHECK_EN
    logic mismatch;

    always_comb begin
        mismatch = (state == WAIT) && (reg_outa != reg_data);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_err  <= 1'b0;
            err_cnt <= '0;
        end else begin
            wr_err <= mismatch;
            if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter with a behavioural register model
// and an ack/rsp_data scoreboard.
module tb_reg_access_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int IC = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   ack;
    logic [W-1:0]    rsp_data;
    logic            busy;
    logic [W-1:0]    reg_data;
    logic            reg_enable;
    logic            reg_reset_n;
    logic [W-1:0]    reg_outa;
`ifdef REG_ACCESS_ARBITER_CHECK_EN
    logic            wr_err;
    logic [7:0]      err_cnt;
`endif

    reg_access_arbiter #(
        .NUM_REQ     (NR),
        .WIDTH       (W),
        .INIT_CYCLES (IC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .reg_data    (reg_data),
        .reg_enable  (reg_enable),
        .reg_reset_n (reg_reset_n),
        .reg_outa    (reg_outa)
`ifdef REG_ACCESS_ARBITER_CHECK_EN
        ,
        .wr_err      (wr_err),
        .err_cnt     (err_cnt)
`endif
    );

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [NR-1:0] mon_ea;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    bit           drop_on_ack = 1'b1;
    bit           corrupt = 1'b0;
    int           ack_log_cyc[$];
    int           ack_log_idx[$];
    logic [W-1:0] reg_q;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural enable-loaded register with active-low async reset.
    always @(posedge clk or negedge reg_reset_n) begin
        if (!reg_reset_n) reg_q <= '0;
        else if (reg_enable) reg_q <= reg_data;
    end
    assign reg_outa = corrupt ? '0 : reg_q;

    // Scoreboard: every ack must match the oldest expected transaction.
    always @(negedge clk) begin
        if (!reset && ack !== '0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack got ack=%b rsp=%h exp no ack", ack, rsp_data);
            end else begin
                mon_e  = sb.pop_front();
                mon_ea = '0;
                mon_ea[mon_e.idx] = 1'b1;
                if (ack !== mon_ea || rsp_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL ack_rsp got ack=%b rsp=%h exp ack=%b rsp=%h",
                             ack, rsp_data, mon_ea, mon_e.data);
                end
            end
        end
    end

    task automatic collect(input int n, input int budget);
        int got;
        got = 0;
        ack_log_cyc.delete();
        ack_log_idx.delete();
        for (int k = 0; k < budget && got < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (ack[i] === 1'b1) begin
                    ack_log_idx.push_back(i);
                    ack_log_cyc.push_back(cyc);
                    got++;
                    if (drop_on_ack) req[i] = 1'b0;
                end
            end
        end
        if (got < n) begin
            total++;
            bad++;
            $display("FAIL ack_timeout got=%0d acks exp=%0d", got, n);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        corrupt  = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp got=%h exp=00", rsp_data); end
        total++; if (reg_data !== 8'h00) begin bad++; $display("FAIL reset_reg_data got=%h exp=00", reg_data); end
        total++; if (reg_enable !== 1'b0) begin bad++; $display("FAIL reset_reg_enable got=%b exp=0", reg_enable); end
        total++; if (reg_reset_n !== 1'b0) begin bad++; $display("FAIL reset_reg_reset_n got=%b exp=0", reg_reset_n); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    endtask

    task automatic test_init();
        int c3;
        reset = 1'b0;
        #1;
        total++; if (reg_reset_n !== 1'b0) begin bad++; $display("FAIL init_c0 got=%b exp=0", reg_reset_n); end
        @(negedge clk);
        total++; if (reg_reset_n !== 1'b0) begin bad++; $display("FAIL init_c1 got=%b exp=0", reg_reset_n); end
        req[1] = 1'b1;
        req_data[1*W +: W] = 8'h11;
        sb.push_back('{idx: 1, data: 8'h11});
        @(negedge clk);
        total++; if (reg_reset_n !== 1'b0) begin bad++; $display("FAIL init_c2 got=%b exp=0", reg_reset_n); end
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL init_no_ack got=%b exp=0000", ack); end
        @(negedge clk);
        total++; if (reg_reset_n !== 1'b1) begin bad++; $display("FAIL init_c3 got=%b exp=1", reg_reset_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_idle_busy got=%b exp=0", busy); end
        c3 = cyc;
        drop_on_ack = 1'b1;
        collect(1, 12);
        if (ack_log_cyc.size() >= 1) begin
            total++;
            if (ack_log_cyc[0] !== c3 + 3) begin
                bad++;
                $display("FAIL init_ack_cycle got=%0d exp=%0d", ack_log_cyc[0], c3 + 3);
            end
        end
    endtask

    task automatic test_single_write();
        int c;
        @(negedge clk);
        req[2] = 1'b1;
        req_data[2*W +: W] = 8'hA5;
        sb.push_back('{idx: 2, data: 8'hA5});
        c = cyc;
        @(negedge clk);
        total++; if (reg_enable !== 1'b1) begin bad++; $display("FAIL wr_enable got=%b exp=1", reg_enable); end
        total++; if (reg_data !== 8'hA5) begin bad++; $display("FAIL wr_data got=%h exp=a5", reg_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
        req_data[2*W +: W] = 8'hFF;
        @(negedge clk);
        total++; if (reg_enable !== 1'b0) begin bad++; $display("FAIL wait_enable got=%b exp=0", reg_enable); end
        total++; if (reg_data !== 8'hA5) begin bad++; $display("FAIL hold_data got=%h exp=a5", reg_data); end
        collect(1, 8);
        if (ack_log_cyc.size() >= 1) begin
            total++;
            if (ack_log_cyc[0] !== c + 3) begin
                bad++;
                $display("FAIL single_latency got=%0d exp=%0d", ack_log_cyc[0], c + 3);
            end
        end
    endtask

    task automatic test_wrap_skip();
        @(negedge clk);
        req = 4'b0101;
        req_data[0*W +: W] = 8'hC3;
        req_data[2*W +: W] = 8'h3C;
        sb.push_back('{idx: 0, data: 8'hC3});
        sb.push_back('{idx: 2, data: 8'h3C});
        collect(2, 20);
        if (ack_log_idx.size() >= 2) begin
            total++; if (ack_log_idx[0] !== 0) begin bad++; $display("FAIL wrap_first got=%0d exp=0", ack_log_idx[0]); end
            total++; if (ack_log_idx[1] !== 2) begin bad++; $display("FAIL skip_second got=%0d exp=2", ack_log_idx[1]); end
            total++;
            if (ack_log_cyc[1] - ack_log_cyc[0] !== 4) begin
                bad++;
                $display("FAIL wrap_spacing got=%0d exp=4", ack_log_cyc[1] - ack_log_cyc[0]);
            end
        end
    endtask

    task automatic test_drop_after_grant();
        @(negedge clk);
        req[3] = 1'b1;
        req_data[3*W +: W] = 8'h5A;
        sb.push_back('{idx: 3, data: 8'h5A});
        @(negedge clk);
        req[3] = 1'b0;
        req_data[3*W +: W] = 8'h00;
        collect(1, 8);
        if (ack_log_idx.size() >= 1) begin
            total++; if (ack_log_idx[0] !== 3) begin bad++; $display("FAIL drop_grant_idx got=%0d exp=3", ack_log_idx[0]); end
        end
    endtask

    task automatic test_contention();
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        @(negedge clk);
        req = 4'b1111;
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = 8'h10 + 8'(i * 17);
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{idx: exp_order[i], data: 8'h10 + 8'(exp_order[i] * 17)});
        end
        drop_on_ack = 1'b0;
        collect(5, 40);
        req = '0;
        drop_on_ack = 1'b1;
        if (ack_log_idx.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (ack_log_idx[i] !== exp_order[i]) begin
                    bad++;
                    $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, ack_log_idx[i], exp_order[i]);
                end
            end
            for (int i = 1; i < 5; i++) begin
                total++;
                if (ack_log_cyc[i] - ack_log_cyc[i-1] !== 4) begin
                    bad++;
                    $display("FAIL rr_spacing[%0d] got=%0d exp=4", i, ack_log_cyc[i] - ack_log_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        req[0] = 1'b1;
        req_data[0*W +: W] = 8'h77;
        sb.push_back('{idx: 0, data: 8'h77});
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midop_busy got=%b exp=1", busy); end
        reset = 1'b1;
        #1;
        total++; if (reg_reset_n !== 1'b0) begin bad++; $display("FAIL midop_reset_n got=%b exp=0", reg_reset_n); end
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL midop_ack got=%b exp=0000", ack); end
        total++; if (reg_enable !== 1'b0) begin bad++; $display("FAIL midop_enable got=%b exp=0", reg_enable); end
        @(negedge clk);
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL midop_ack_held got=%b exp=0000", ack); end
        reset = 1'b0;
        collect(1, 20);
    endtask

    task automatic test_check();
`ifdef REG_ACCESS_ARBITER_CHECK_EN
        @(negedge clk);
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL chk_err_init got=%b exp=0", wr_err); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL chk_cnt_init got=%0d exp=0", err_cnt); end
        corrupt = 1'b1;
        req[1] = 1'b1;
        req_data[1*W +: W] = 8'h3C;
        sb.push_back('{idx: 1, data: 8'h00});
        collect(1, 10);
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL chk_err1 got=%b exp=1", wr_err); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL chk_cnt1 got=%0d exp=1", err_cnt); end
        @(negedge clk);
        req[2] = 1'b1;
        req_data[2*W +: W] = 8'h81;
        sb.push_back('{idx: 2, data: 8'h00});
        collect(1, 10);
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL chk_err2 got=%b exp=1", wr_err); end
        total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL chk_cnt2 got=%0d exp=2", err_cnt); end
        corrupt = 1'b0;
        @(negedge clk);
        req[3] = 1'b1;
        req_data[3*W +: W] = 8'h99;
        sb.push_back('{idx: 3, data: 8'h99});
        collect(1, 10);
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL chk_err_clean got=%b exp=0", wr_err); end
        total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL chk_cnt_clean got=%0d exp=2", err_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_init();
        test_single_write();
        test_wrap_skip();
        test_drop_after_grant();
        test_contention();
        test_reset_midop();
        test_check();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d pending exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
